// File: rtl/pcs25g_gray_pkg.sv
// rtl/pcs25g_gray_pkg.sv - shared pointer width, FSM encodings and init length for the Gray pointer link
package pcs25g_gray_pkg;

  localparam int PTR_W        = 4;
  localparam int INIT_CYC_DEF = 3;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_TRACK = 2'd1,
    ST_ERROR = 2'd2
  } state_e;

endpackage

// File: rtl/gray_ptr_rx_16_if.sv
// rtl/gray_ptr_rx_16_if.sv - read-side bundle: remote Gray pointer in, read request/status out
interface gray_ptr_rx_16_if;
  import pcs25g_gray_pkg::*;

  logic [PTR_W-1:0] gray_in;
  logic             rd_en;
  logic             err_clr;
  logic             ready;
  logic             empty;
  logic [PTR_W-1:0] occupancy;
  logic [PTR_W-1:0] rptr;
  logic             err;

  // Consumer side: supplies pointer and requests, observes status
  modport master (
    output gray_in, rd_en, err_clr,
    input  ready, empty, occupancy, rptr, err
  );

  // Receiver block side
  modport slave (
    input  gray_in, rd_en, err_clr,
    output ready, empty, occupancy, rptr, err
  );

endinterface

// File: rtl/graydecoder_16.sv
// rtl/graydecoder_16.sv - combinational 4-bit Gray-to-binary decode, inverse of the link encoder
module graydecoder_16 (
  input  logic [3:0] g,
  output logic [3:0] b
);

  // Each binary bit is the XOR of all Gray bits at or above it
  always_comb begin
    b[3] = g[3];
    b[2] = ^g[3:2];
    b[1] = ^g[3:1];
    b[0] = ^g[3:0];
  end

endmodule

// File: rtl/gray_ptr_rx_16.sv
// rtl/gray_ptr_rx_16.sv - Gray pointer receiver: 2-flop sync, decode, align, local read pointer; checker under GRAY_PTR_RX_CHECK_EN
module gray_ptr_rx_16
  import pcs25g_gray_pkg::*;
#(
  parameter int INIT_CYC = INIT_CYC_DEF
) (
  input  logic           clk,
  input  logic           rst,
  gray_ptr_rx_16_if.slave bus
);

  localparam int CNT_W = $clog2(INIT_CYC + 1);

  logic [PTR_W-1:0] sync1_q, sync1_d;
  logic [PTR_W-1:0] sync2_q, sync2_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e           state_q, state_d;
  logic [PTR_W-1:0] dec;
  logic [PTR_W-1:0] occ;
  logic             track;
  logic             rd_ok;
`ifdef GRAY_PTR_RX_CHECK_EN
  logic             err_q, err_d;
  logic [PTR_W-1:0] delta;
  logic             viol;
`endif

  graydecoder_16 u_dec (
    .g (sync2_q),
    .b (dec)
  );

  assign track = (state_q == ST_TRACK);
  assign occ   = wptr_q - rptr_q;
  assign rd_ok = bus.rd_en && (occ != '0);

`ifdef GRAY_PTR_RX_CHECK_EN
  // Remote pointer may only hold or step by one, and must not step into a full buffer
  always_comb begin
    delta = dec - wptr_q;
    viol  = (delta > 4'd1) || ((delta == 4'd1) && (occ == 4'd15));
  end
`endif

  // Next-state: synchronizer shift, init countdown, pointer tracking and checking
  always_comb begin
    sync1_d = bus.gray_in;
    sync2_d = sync1_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    state_d = state_q;
`ifdef GRAY_PTR_RX_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      ST_INIT: begin
        if (cnt_q == CNT_W'(INIT_CYC)) begin
          // Align both pointers to the remote value so the buffer starts empty
          wptr_d  = dec;
          rptr_d  = dec;
          state_d = ST_TRACK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_TRACK: begin
        wptr_d = dec;
        if (rd_ok) begin
          rptr_d = rptr_q + 4'd1;
        end
`ifdef GRAY_PTR_RX_CHECK_EN
        if (viol) begin
          err_d   = 1'b1;
          state_d = ST_ERROR;
        end
`endif
      end
`ifdef GRAY_PTR_RX_CHECK_EN
      ST_ERROR: begin
        wptr_d = dec;
        if (bus.err_clr) begin
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_INIT;
        end
      end
`endif
      default: begin
        cnt_d   = '0;
        state_d = ST_INIT;
      end
    endcase
  end

  // State registers with synchronous reset back to INIT
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      state_q <= ST_INIT;
`ifdef GRAY_PTR_RX_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
`ifdef GRAY_PTR_RX_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign bus.ready     = track;
  assign bus.empty     = !track || (occ == '0);
  assign bus.occupancy = track ? occ : '0;
  assign bus.rptr      = rptr_q;
`ifdef GRAY_PTR_RX_CHECK_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif

endmodule
